// File: rtl/seq_addsub_chunked_pkg.sv
// Shared types and sizing helpers for the chunked sequential adder/subtractor.
// The optional zero flag is enabled with SEQ_ADDSUB_ZERO_FLAG_EN.
package seq_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of chunk steps per operation.
  function automatic int calc_n(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Step counter width; never below one bit so N=1 still has a counter.
  function automatic int calc_cnt_w(input int width, input int chunk);
    int n;
    n = width / chunk;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_addsub_chunked_if.sv
// Request/response bundle for seq_addsub_chunked; carries the zero flag only
// when SEQ_ADDSUB_ZERO_FLAG_EN is defined.
interface seq_addsub_chunked_if #(
  parameter int WIDTH = 16
);
  // Handshake: start is honoured only while idle or in the done cycle; operands
  // and cin are captured on that edge. busy is high for the whole run, done
  // pulses for one cycle, and s/cout/ovf stay valid until the next done.
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
`ifdef SEQ_ADDSUB_ZERO_FLAG_EN
  logic             zero;

  modport master (output start, sub, a, b, cin,
                  input  busy, done, s, cout, ovf, zero);
  modport slave  (input  start, sub, a, b, cin,
                  output busy, done, s, cout, ovf, zero);
`else
  modport master (output start, sub, a, b, cin,
                  input  busy, done, s, cout, ovf);
  modport slave  (input  start, sub, a, b, cin,
                  output busy, done, s, cout, ovf);
`endif
endinterface

// File: rtl/seq_addsub_chunked_rca_chunk.sv
// Combinational W-bit ripple-carry slice used for one chunk per cycle.
module rca_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic c;

  always_comb begin
    s = '0;
    c = cin;
    for (int i = 0; i < W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/seq_addsub_chunked.sv
// Multi-cycle adder/subtractor, CHUNK bits per clock with a registered carry.
// Define SEQ_ADDSUB_ZERO_FLAG_EN to add the registered zero-result flag.
module seq_addsub_chunked
  import seq_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                clk,
  input  logic                rst,
  seq_addsub_chunked_if.slave bus,
  output state_t              state_dbg
);

  localparam int N  = calc_n(WIDTH, CHUNK);
  localparam int CW = calc_cnt_w(WIDTH, CHUNK);

  if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
    $error("seq_addsub_chunked: WIDTH must be a multiple of CHUNK");
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] op_a, op_b, work, sum_full;
  logic             carry;
  logic [CW-1:0]    count;
  logic [CHUNK-1:0] chunk_a, chunk_b, chunk_s;
  logic             chunk_c;
  logic             accept, last;
  logic [WIDTH-1:0] s_q;
  logic             cout_q, ovf_q;

  assign accept    = bus.start && ((state == IDLE) || (state == DONE));
  assign last      = (state == RUN) && (count == CW'(N - 1));
  assign state_dbg = state;

  assign chunk_a = op_a[int'(count)*CHUNK +: CHUNK];
  assign chunk_b = op_b[int'(count)*CHUNK +: CHUNK];

  rca_chunk #(.W(CHUNK)) u_rca (
    .a    (chunk_a),
    .b    (chunk_b),
    .cin  (carry),
    .s    (chunk_s),
    .cout (chunk_c)
  );

  // Working value with the current chunk merged in; complete on the last step.
  always_comb begin
    sum_full = work;
    sum_full[int'(count)*CHUNK +: CHUNK] = chunk_s;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == RUN);
    bus.done = (state == DONE);
  end

  // Subtraction runs as a + ~b + ~borrow, so cout=1 means no borrow.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      work   <= '0;
      carry  <= 1'b0;
      count  <= '0;
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      op_a  <= bus.a;
      op_b  <= bus.sub ? ~bus.b : bus.b;
      carry <= bus.sub ? ~bus.cin : bus.cin;
      count <= '0;
    end else if (state == RUN) begin
      work  <= sum_full;
      carry <= chunk_c;
      count <= count + 1'b1;
      if (last) begin
        s_q    <= sum_full;
        cout_q <= chunk_c;
        ovf_q  <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                  (sum_full[WIDTH-1] != op_a[WIDTH-1]);
      end
    end
  end

  assign bus.s    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

`ifdef SEQ_ADDSUB_ZERO_FLAG_EN
  logic zero_q;

  always_ff @(posedge clk) begin
    if (rst)       zero_q <= 1'b0;
    else if (last) zero_q <= (sum_full == '0);
  end

  assign bus.zero = zero_q;
`endif

endmodule

// File: tb/tb_seq_addsub_chunked.sv
// Self-checking bench for seq_addsub_chunked: 16/4 main instance plus 32/8 and 16/16.
module tb_seq_addsub_chunked;
  import seq_addsub_pkg::*;

  localparam int W = 16;
  localparam int C = 4;
  localparam int N = W / C;

  typedef struct {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t state_dbg, state_w, state_n1;

  int n_vec = 0;
  int n_err = 0;
  logic [W+1:0] exp_q[$];

  always #5 clk = ~clk;

  seq_addsub_chunked_if #(.WIDTH(16)) bus();
  seq_addsub_chunked_if #(.WIDTH(32)) bus_w();
  seq_addsub_chunked_if #(.WIDTH(16)) bus_n1();

  seq_addsub_chunked #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg));
  seq_addsub_chunked #(.WIDTH(32), .CHUNK(8)) dut_w (
    .clk(clk), .rst(rst), .bus(bus_w), .state_dbg(state_w));
  seq_addsub_chunked #(.WIDTH(16), .CHUNK(16)) dut_n1 (
    .clk(clk), .rst(rst), .bus(bus_n1), .state_dbg(state_n1));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on W+1 bits.
  function automatic logic [W+1:0] model(input logic sub, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic cin);
    logic [W:0] full;
    logic       co, ov;
    if (!sub) begin
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      co   = full[W];
      ov   = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    end else begin
      full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
      co   = ~full[W];
      ov   = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
    end
    return {full[W-1:0], co, ov};
  endfunction

  // Scoreboard: every done pops one expected {s, cout, ovf}.
  always @(negedge clk) begin
    logic [W+1:0] e;
    if (!rst && bus.done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(bus.done), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("result", 64'({bus.s, bus.cout, bus.ovf}), 64'(e));
`ifdef SEQ_ADDSUB_ZERO_FLAG_EN
        check("zero_flag", 64'(bus.zero), 64'(e[W+1:2] == '0));
`endif
      end
    end
  end

  task automatic drive(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin);
    bus.start = 1'b1;
    bus.sub   = sub;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
  endtask

  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc = 0;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.busy) busy_cnt++;
      if (bus.done) break;
    end
    if (!bus.done) check("done_timeout", 64'(0), 64'(1));
  endtask

  task automatic run_op(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic [W+1:0] e);
    int cyc, bc;
    @(negedge clk);
    drive(sub, a, b, cin);
    exp_q.push_back(e);
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(cyc, bc);
    check("latency", 64'(cyc), 64'(N + 1));
    check("busy_cycles", 64'(bc), 64'(N));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  vec_t vecs[10];

  initial begin
    int cyc, bc;
    logic [W+1:0] e1, e2;
    logic [W-1:0] ra, rb;
    logic rs, rc;

    vecs[0] = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 16'h0007, 16'h0005, 1'b1, 16'h0001, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0};

    bus.start = 0; bus.sub = 0; bus.a = '0; bus.b = '0; bus.cin = 0;
    bus_w.start = 0; bus_w.sub = 0; bus_w.a = '0; bus_w.b = '0; bus_w.cin = 0;
    bus_n1.start = 0; bus_n1.sub = 0; bus_n1.a = '0; bus_n1.b = '0; bus_n1.cin = 0;

    // Reset state
    rst = 1'b1;
    idle_cycles(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_s", 64'(bus.s), 64'(0));
    check("rst_cout", 64'(bus.cout), 64'(0));
    check("rst_ovf", 64'(bus.ovf), 64'(0));
    check("rst_state", 64'(state_dbg), 64'(IDLE));

    // Table vectors
    for (int i = 0; i < 10; i++)
      run_op(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin,
             {vecs[i].es, vecs[i].ec, vecs[i].eo});

    // Random vectors against the arithmetic model
    for (int i = 0; i < 8; i++) begin
      ra = W'($urandom_range(0, 65535));
      rb = W'($urandom_range(0, 65535));
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      run_op(rs, ra, rb, rc, model(rs, ra, rb, rc));
    end

    // Result holds through IDLE
    @(negedge clk);
    check("hold_idle_s", 64'(bus.s), 64'(model(rs, ra, rb, rc) >> 2));

    // start while busy is ignored
    @(negedge clk);
    drive(1'b0, 16'h0102, 16'h0304, 1'b0);
    exp_q.push_back(model(1'b0, 16'h0102, 16'h0304, 1'b0));
    @(posedge clk);
    #1 drive(1'b1, 16'hAAAA, 16'h5555, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(cyc, bc);
    idle_cycles(6);

    // Back-to-back: start in the DONE cycle
    e1 = model(1'b0, 16'h00F0, 16'h0F00, 1'b0);
    e2 = model(1'b1, 16'h1000, 16'h0001, 1'b0);
    @(negedge clk);
    drive(1'b0, 16'h00F0, 16'h0F00, 1'b0);
    exp_q.push_back(e1);
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(cyc, bc);
    drive(1'b1, 16'h1000, 16'h0001, 1'b0);
    exp_q.push_back(e2);
    @(posedge clk);
    #1 bus.start = 1'b0;
    check("b2b_busy", 64'(bus.busy), 64'(1));
    check("hold_run_s", 64'(bus.s), 64'(e1[W+1:2]));
    wait_done(cyc, bc);
    check("b2b_latency", 64'(cyc), 64'(N + 1));

    // Reset in the second RUN cycle
    @(negedge clk);
    drive(1'b0, 16'h4000, 16'h2000, 1'b1);
    exp_q.push_back(model(1'b0, 16'h4000, 16'h2000, 1'b1));
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", 64'(bus.busy), 64'(0));
    check("midrst_done", 64'(bus.done), 64'(0));
    check("midrst_s", 64'(bus.s), 64'(0));
    check("midrst_cout", 64'(bus.cout), 64'(0));
    check("midrst_state", 64'(state_dbg), 64'(IDLE));
    idle_cycles(6);
    run_op(1'b0, 16'h4000, 16'h2000, 1'b1, model(1'b0, 16'h4000, 16'h2000, 1'b1));

    // WIDTH=32, CHUNK=8
    @(negedge clk);
    bus_w.start = 1'b1; bus_w.sub = 1'b0; bus_w.cin = 1'b0;
    bus_w.a = 32'hFFFF_FFFF; bus_w.b = 32'h0000_0001;
    @(posedge clk);
    #1 bus_w.start = 1'b0;
    bc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_w.busy) bc++;
      if (bus_w.done) break;
    end
    check("w32_done", 64'(bus_w.done), 64'(1));
    check("w32_s", 64'(bus_w.s), 64'(0));
    check("w32_cout", 64'(bus_w.cout), 64'(1));
    check("w32_ovf", 64'(bus_w.ovf), 64'(0));
    check("w32_busy_cycles", 64'(bc), 64'(4));

    // CHUNK=WIDTH: one RUN cycle
    @(negedge clk);
    bus_n1.start = 1'b1; bus_n1.sub = 1'b1; bus_n1.cin = 1'b0;
    bus_n1.a = 16'h1234; bus_n1.b = 16'h0001;
    @(posedge clk);
    #1 bus_n1.start = 1'b0;
    bc = 0;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (bus_n1.busy) bc++;
      if (bus_n1.done) break;
    end
    check("n1_done", 64'(bus_n1.done), 64'(1));
    check("n1_s", 64'(bus_n1.s), 64'(16'h1233));
    check("n1_cout", 64'(bus_n1.cout), 64'(1));
    check("n1_busy_cycles", 64'(bc), 64'(1));
    check("n1_latency", 64'(cyc), 64'(2));

    idle_cycles(2);
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_addsub_chunked.md
Name: seq_addsub_chunked

Overview:
- Parametrised multi-cycle adder/subtractor; successor to the fixed 16-bit ripple-carry adder.
- Processes CHUNK bits per clock through a CHUNK-bit ripple slice.
- The carry is registered between chunks, giving a short critical path for wide operands.
- Start/busy/done handshake; result plus carry-out and signed-overflow flags held until the next operation.

Parameters:
WIDTH, 16, operand/result width in bits
CHUNK, 4, bits added per cycle; WIDTH % CHUNK == 0 required (elaboration error otherwise)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE or DONE
sub  input  1  0: s=a+b+cin; 1: s=a-b-cin (borrow-in)
a  input  WIDTH  operand A, sampled with start
b  input  WIDTH  operand B, sampled with start
cin  input  1  carry-in (add) / borrow-in (sub), sampled with start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when result is valid
s  output  WIDTH  result, registered
cout  output  1  carry-out; for sub, 1 = no borrow
ovf  output  1  two's-complement overflow

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, s=0, cout=0, ovf=0, internal regs=0.
- N = WIDTH/CHUNK.
- States: IDLE, RUN, DONE.
- IDLE --start--> RUN. On this edge, latch:
  - opA=a
  - opB = sub ? ~b : b
  - carry = sub ? ~cin : cin
  - count=0
- RUN: on each edge, add chunk [count*CHUNK +: CHUNK] of opA, opB and carry.
  - Write the sum into the working register; carry <= chunk carry-out; count++.
  - When count==N-1 on that edge, go to DONE.
  - On that same edge, load s with the full result, cout with the final carry, and ovf = (opA[W-1]==opB[W-1]) && (sum[W-1]!=opA[W-1]).
- DONE: done=1 for exactly one cycle, busy=0.
  - start in DONE is accepted like IDLE (back-to-back ops, next state RUN).
  - Otherwise go to IDLE.
- Latency: start sampled at edge E → done high in the cycle after edge E+N. Throughput is one op per N+1 cycles.
- busy is high for exactly N cycles per op.
- start while busy is ignored; operands are not re-latched.
- s, cout and ovf change only at the RUN→DONE edge. They hold their value through IDLE and the next RUN.
- rst has priority at any time, including mid-RUN: return to IDLE, clear all outputs, no done pulse.
- Wrap-around: the sum is modulo 2^WIDTH; the carry beyond the MSB goes to cout only.
- N=1 (CHUNK=WIDTH) is legal: RUN lasts one cycle.
- Counter width is $clog2(N) with a minimum of 1.

Optional Feature:
- Macro: SEQ_ADDSUB_ZERO_FLAG_EN.
- When defined, add output port zero (1 bit): high when s==0. It is registered and updated on the same edge as s, and resets to 0.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package seq_addsub_pkg holds:
  - the state enum typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - a localparam function computing N and the counter width from WIDTH/CHUNK
- One sub-module: rca_chunk, a combinational CHUNK-bit ripple-carry slice with ports a, b, cin, s, cout.
  - Instantiate it once; the top-level selects the chunk using count.

Test Plan (WIDTH=16, CHUNK=4 unless stated):
1. Add: a=FFFF, b=FFFF, cin=0, sub=0, start for 1 cycle → busy high 4 cycles, then done pulse; s=FFFE, cout=1, ovf=0.
2. Subtract: a=0005, b=0007, cin=0, sub=1 → s=FFFE, cout=0 (borrow), ovf=0. Then a=0007, b=0005, cin=1 → s=0001, cout=1.
3. Signed overflow: a=7FFF, b=0001, sub=0 → s=8000, ovf=1, cout=0. Then a=8000, b=0001, sub=1 → s=7FFF, ovf=1.
4. Handshake:
   - Re-assert start with new operands while busy → ignored; the first result is unchanged.
   - start in the DONE cycle → second op runs immediately; its done arrives 5 cycles after the first.
5. Reset mid-op: assert rst in the 2nd RUN cycle → next cycle busy=0, s=0, cout=0, no done pulse. A subsequent start completes normally.
6. Parameters:
   - WIDTH=32, CHUNK=8: a=FFFFFFFF, b=00000001, cin=0 → s=00000000, cout=1, busy for 4 cycles.
   - WIDTH=16, CHUNK=16 → busy for 1 cycle.
   - With SEQ_ADDSUB_ZERO_FLAG_EN defined → zero=1 for s=0000.
